// File: rtl/xsim_msg_deframer.sv
// Receive-side portal message deframer: parses header beats and queues payload words with method/last tags.
// Define XSIM_DEFRAMER_TRACE_EN to compile header and malformed-length trace messages.
module xsim_msg_deframer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [31:0] in_beat,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [15:0] out_method,
    output logic        out_last,
    output logic        out_nodata,
    input  logic        out_ready,
    output logic        err_len,
    output logic        busy
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t        state, state_next;
    logic [15:0]   remaining, remaining_next;
    logic [15:0]   method_q, method_next;
    logic          accept, pop, push, err_next;
    logic [49:0]   push_entry, head;
    logic [49:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            method_q  <= '0;
            err_len   <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            method_q  <= method_next;
            err_len   <= err_next;
        end
    end

    // Entry layout: {nodata, last, method[15:0], data[31:0]}
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        method_next    = method_q;
        push           = 1'b0;
        push_entry     = '0;
        err_next       = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_beat[15:0] == 16'd0) begin
                        err_next = 1'b1;
                    end else if (in_beat[15:0] == 16'd1) begin
                        push       = 1'b1;
                        push_entry = {1'b1, 1'b1, in_beat[31:16], 32'h0};
                    end else begin
                        method_next    = in_beat[31:16];
                        remaining_next = in_beat[15:0] - 16'd1;
                        state_next     = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    push       = 1'b1;
                    push_entry = {1'b0, (remaining == 16'd1), method_q, in_beat};
                    if (remaining != 16'd0) begin
                        remaining_next = remaining - 16'd1;
                    end
                    if (remaining <= 16'd1) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Storage is never reset, so head contents are masked whenever the FIFO is empty.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count != '0);
        in_ready  = !RST && (count < FULL);
        busy      = (state == PAYLOAD);
        if (out_valid) begin
            {out_nodata, out_last, out_method, out_data} = head;
        end else begin
            {out_nodata, out_last, out_method, out_data} = '0;
        end
    end

`ifdef XSIM_DEFRAMER_TRACE_EN
    always_ff @(posedge CLK) begin
        if (accept && state == IDLE) begin
            $display("xsim_msg_deframer: header method=%0d length=%0d at %0t",
                     in_beat[31:16], in_beat[15:0], $time);
            if (in_beat[15:0] == 16'd0) begin
                $display("xsim_msg_deframer: warning, zero-length header dropped, beat=%h at %0t",
                         in_beat, $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_xsim_msg_deframer.sv
// Scoreboard bench for xsim_msg_deframer: a header-parsing model queues expected FIFO entries on each accepted beat.
module tb_xsim_msg_deframer;

    localparam int unsigned DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_beat = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_method;
    logic        out_last;
    logic        out_nodata;
    logic        out_ready = 1'b0;
    logic        err_len;
    logic        busy;

    always #5 CLK = ~CLK;

    xsim_msg_deframer #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_beat    (in_beat),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_method (out_method),
        .out_last   (out_last),
        .out_nodata (out_nodata),
        .out_ready  (out_ready),
        .err_len    (err_len),
        .busy       (busy)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [49:0] sb[$];
    logic        m_payload = 1'b0;
    logic [15:0] m_rem     = '0;
    logic [15:0] m_method  = '0;
    logic        exp_err   = 1'b0;
    logic        acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [31:0] b);
        if (!m_payload) begin
            if (b[15:0] == 16'd0) begin
                exp_err = 1'b1;
            end else if (b[15:0] == 16'd1) begin
                sb.push_back({1'b1, 1'b1, b[31:16], 32'h0});
            end else begin
                m_method  = b[31:16];
                m_rem     = b[15:0] - 16'd1;
                m_payload = 1'b1;
            end
        end else begin
            sb.push_back({1'b0, (m_rem == 16'd1), m_method, b});
            m_rem = m_rem - 16'd1;
            if (m_rem == 16'd0) m_payload = 1'b0;
        end
    endtask

    // Called at posedge+1; samples one cycle's handshakes before the next edge.
    task automatic step(input logic v, input logic [31:0] b, input logic r, output logic accepted);
        logic [49:0] e;
        in_valid  = v;
        in_beat   = b;
        out_ready = r;
        exp_err   = 1'b0;
        #1;
        check("in_ready", in_ready, sb.size() < DEPTH);
        check("out_valid", out_valid, sb.size() != 0);
        if (!out_valid) begin
            check("empty_head_zero", {out_nodata, out_last, out_method, out_data}, '0);
        end else if (out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("entry", {out_nodata, out_last, out_method, out_data}, e);
        end
        accepted = in_valid && in_ready;
        if (accepted) model_accept(b);
        @(posedge CLK);
        #1;
        check("err_len", err_len, exp_err);
        check("busy", busy, m_payload);
    endtask

    task automatic send(input logic [31:0] b, input logic r);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 50 && !a; i++) step(1'b1, b, r, a);
        check("send_accept", a, 1'b1);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1'b0, '0, 1'b1, a);
        check("drained", sb.size(), 0);
        step(1'b0, '0, 1'b1, a);
    endtask

    initial begin
        logic [31:0] beats[$];
        int          idx;
        int unsigned len;

        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", {out_nodata, out_last, out_method, out_data}, '0);
        check("rst_err_busy", {err_len, busy}, 2'b00);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Two-payload message
        send(32'h0005_0003, 1'b1);
        send(32'h0000_000A, 1'b1);
        send(32'h0000_000B, 1'b1);
        drain();

        // Header-only message
        send(32'h0007_0001, 1'b1);
        drain();

        // Malformed length, then a valid single-payload message
        send(32'h0009_0000, 1'b1);
        send(32'h0002_0002, 1'b1);
        send(32'h0000_0055, 1'b1);
        drain();

        // Fill to full with the consumer stalled
        send(32'h0001_0015, 1'b0);
        for (int k = 1; k <= 16; k++) send(32'h100 + k, 1'b0);
        step(1'b1, 32'h111, 1'b0, acc);
        check("full_refuse", acc, 1'b0);
        step(1'b1, 32'h111, 1'b1, acc);
        check("full_pop_refuse", acc, 1'b0);
        step(1'b1, 32'h111, 1'b1, acc);
        check("after_pop_accept", acc, 1'b1);
        for (int k = 18; k <= 20; k++) send(32'h100 + k, 1'b1);
        drain();

        // Reset in the middle of a message with buffered words
        send(32'h0004_0005, 1'b0);
        send(32'h0000_00C1, 1'b0);
        send(32'h0000_00C2, 1'b0);
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs", {out_nodata, out_last, out_method, out_data}, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        sb.delete();
        m_payload = 1'b0;
        m_rem     = '0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send(32'h0003_0002, 1'b1);
        send(32'h0000_0077, 1'b1);
        drain();

        // Random message mix with random valid/ready
        for (int m = 0; m < 10; m++) begin
            len = $urandom_range(0, 4);
            beats.push_back({16'(m + 32), 16'(len)});
            for (int j = 1; j < int'(len); j++) beats.push_back($urandom);
        end
        idx = 0;
        for (int c = 0; c < 600 && idx < beats.size(); c++) begin
            step(($urandom_range(0, 3) != 0), beats[idx], 1'($urandom_range(0, 1)), acc);
            if (acc) idx++;
        end
        check("random_feed", idx, beats.size());
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xsim_msg_deframer.md
# xsim_msg_deframer

Receive-side deframer for simulated portal traffic. Takes the raw 32-bit beat stream delivered by the simulator's DPI sink (software → hardware), parses each portal message header, and presents payload words to the portal request logic through a FIFO with a valid/ready handshake, tagged with method id and last-word marker. It is the consuming end of the message-beat channel, the counterpart of the hardware → software beat source.

## Interface
- DEPTH, 16: payload FIFO entries; power of two, ≥2.
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat available from DPI sink (its src_rdy).
- in_beat  in  32  header or payload beat.
- in_ready  out  1  deframer accepts beat this cycle; DPI wrapper pops only when in_valid && in_ready.
- out_valid  out  1  FIFO head valid.
- out_data  out  32  payload word (0 when out_nodata).
- out_method  out  16  method id of the message owning this word.
- out_last  out  1  final entry of message.
- out_nodata  out  1  entry represents a header-only (zero-argument) message.
- out_ready  in  1  consumer pops head when out_valid && out_ready.
- err_len  out  1  one-cycle pulse: malformed header (length 0) dropped.
- busy  out  1  1 while in PAYLOAD state.

## Operation
- Header beat: method = in_beat[31:16], length = in_beat[15:0] = total words including header.
- States: IDLE (expecting header), PAYLOAD (remaining > 0).
- IDLE, accepted beat:
  - length 0: drop, pulse err_len, stay IDLE.
  - length 1: enqueue one entry {data=0, method, last=1, nodata=1}; stay IDLE.
  - length ≥2: latch method, remaining = length−1; enqueue nothing; → PAYLOAD.
- PAYLOAD, accepted beat: enqueue {in_beat, method, last=(remaining==1), nodata=0}; remaining−1; → IDLE when remaining reaches 0.
- remaining is 16-bit unsigned; max message 65535 words, never wraps (decrement only while >0).
- FIFO: DEPTH entries × 50 bits; circular read/write pointers, log2(DEPTH)+1-bit occupancy count.
- in_ready = (count < DEPTH). Header beats with length ≥2 or 0 need no slot but still use in_ready (uniform rule).
- Pop when out_valid && out_ready; pointers wrap modulo DEPTH.
- Outputs out_* driven directly from FIFO head storage; undefined content not exposed (out_valid=0 → out_data/out_method 0).

## Timing
- Reset (async assert, sync-released use on next posedge): state IDLE, remaining 0, count 0, pointers 0; in_ready=1 while RST low after release, in_ready=0 during reset; out_valid 0, out_data 0, out_method 0, out_last 0, out_nodata 0, err_len 0, busy 0.
- Reset mid-message: partial message and all buffered entries discarded; next beat parsed as header.
- Enqueue latency: beat accepted at edge N → out_valid=1 after edge N (visible cycle N+1).
- Simultaneous push and pop: count unchanged; allowed at any occupancy below full.
- Full (count==DEPTH): in_ready=0 even if a pop occurs same cycle (no bypass); in_ready returns 1 the cycle after the pop.
- Empty with push: no fall-through; out_valid rises one cycle later.
- err_len asserted exactly the cycle after the offending header edge, for one cycle.
- Throughput: one beat per cycle in and out sustained when not full.

## Configuration
- XSIM_DEFRAMER_TRACE_EN defined: on each accepted header, $display method, length, and simulation time; on err_len, $display warning with raw beat.
- Undefined: no display statements compiled; functional behaviour identical.

## Test plan
- Header 0x0005_0003 then beats 0xA, 0xB, out_ready=1 → two entries method 5: (0xA, last=0), (0xB, last=1); busy high for 2 accepted beats.
- Header 0x0007_0001 → single entry method 7, out_nodata=1, out_last=1, out_data=0; state stays IDLE.
- Header 0x0009_0000 → err_len pulse one cycle, nothing enqueued; following header 0x0002_0002 + 0x55 yields one entry (0x55, method 2, last=1).
- DEPTH=16, out_ready=0, header 0x0001_0015 (20 payload): in_ready drops after 16 payload beats; raising out_ready drains in order, remaining 4 accepted, last on word 20.
- Full FIFO, push and pop same cycle → push refused, count 15, in_ready=1 next cycle.
- RST asserted after 2 of 4 payload beats → outputs zero immediately; new header 0x0003_0002 + 0x77 produces (0x77, method 3, last=1).
